// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, request/ready imem handshake and wrong-path drop.
// Optional FETCH_PERF_CNT_EN adds saturating stall/bubble cycle counters.
module fetch_stage #(
   parameter int                     PC_width    = 32,
   parameter int                     Instr_width = 32,
   parameter logic [PC_width-1:0]    RESET_PC    = '0,
   parameter logic [Instr_width-1:0] NOP_INSTR   = '0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   StallF,
   input  logic                   StallD,
   input  logic [1:0]             PCSrcD,
   input  logic [PC_width-1:0]    PCBranchD,
   input  logic [PC_width-1:0]    PCJumpD,
   output logic                   ImemReq,
   output logic [PC_width-1:0]    ImemAddr,
   input  logic [Instr_width-1:0] ImemRdata,
   input  logic                   ImemReady,
   output logic [PC_width-1:0]    PCF,
   output logic [Instr_width-1:0] InstrD,
   output logic [PC_width-1:0]    PCPlus4D,
   output logic                   ValidD
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            StallCycles,
   output logic [31:0]            BubbleCycles
`endif
);

   typedef enum logic {S_FETCH, S_DROP} state_t;

   state_t                 state_q, state_d;
   logic [PC_width-1:0]    pc_q, pc_d;
   logic [PC_width-1:0]    pending_q, pending_d;
   logic [Instr_width-1:0] instr_q, instr_d;
   logic [PC_width-1:0]    pcplus4_q, pcplus4_d;
   logic                   valid_q, valid_d;

   logic                   redirect;
   logic                   take;
   logic [PC_width-1:0]    target;
   logic [PC_width-1:0]    pc_plus4;

   assign redirect = (PCSrcD != 2'b00) & ~StallD;
   assign target   = PCSrcD[1] ? PCJumpD : PCBranchD;
   assign pc_plus4 = pc_q + PC_width'(4);
   assign take     = (state_q == S_FETCH) & ImemReady & ~StallF & ~redirect;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pending_d = pending_q;
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;

      case (state_q)
         S_FETCH: begin
            // A redirect without a response leaves a stale request outstanding; drain it first.
            if (redirect) begin
               if (ImemReady) begin
                  pc_d = target;
               end else begin
                  pending_d = target;
                  state_d   = S_DROP;
               end
            end else if (take) begin
               pc_d = pc_plus4;
            end
         end
         S_DROP: begin
            if (redirect)
               pending_d = target;
            if (ImemReady) begin
               pc_d    = redirect ? target : pending_q;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase

      if (!StallD) begin
         if (take) begin
            instr_d   = ImemRdata;
            pcplus4_d = pc_plus4;
            valid_d   = 1'b1;
         end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         pending_q <= '0;
         instr_q   <= NOP_INSTR;
         pcplus4_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= pending_d;
         instr_q   <= instr_d;
         pcplus4_q <= pcplus4_d;
         valid_q   <= valid_d;
      end
   end

   assign ImemReq  = ~RST;
   assign ImemAddr = pc_q;
   assign PCF      = pc_q;
   assign InstrD   = instr_q;
   assign PCPlus4D = pcplus4_q;
   assign ValidD   = valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (~ImemReady && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (~StallD && ~take && bubble_cnt_q != 32'hFFFF_FFFF)
         bubble_cnt_d = bubble_cnt_q + 32'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign StallCycles  = stall_cnt_q;
   assign BubbleCycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random traffic vs a reference model.
module tb_fetch_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        StallF, StallD;
   logic [1:0]  PCSrcD;
   logic [31:0] PCBranchD, PCJumpD;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic [31:0] ImemRdata;
   logic        ImemReady;
   logic [31:0] PCF, InstrD, PCPlus4D;
   logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] StallCycles, BubbleCycles;
`endif

   always #5 CLK = ~CLK;

   fetch_stage dut (
      .CLK(CLK), .RST(RST), .StallF(StallF), .StallD(StallD),
      .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .PCJumpD(PCJumpD),
      .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata), .ImemReady(ImemReady),
      .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
      , .StallCycles(StallCycles), .BubbleCycles(BubbleCycles)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   assign ImemRdata = mem_word(ImemAddr);

   int checks = 0;
   int passed = 0;

   // Reference state: where fetch is, whether a stale response must be swallowed, and IF/ID contents.
   logic [31:0] m_pc, m_pend, m_instr, m_pc4;
   logic        m_drop, m_valid;
   logic [31:0] m_stall_cnt, m_bub_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step(input logic rst, input logic sf, input logic sd, input logic [1:0] src,
                       input logic [31:0] br, input logic [31:0] jp, input logic rdy);
      logic        redir, taken;
      logic [31:0] tgt;
      @(negedge CLK);
      RST = rst; StallF = sf; StallD = sd; PCSrcD = src;
      PCBranchD = br; PCJumpD = jp; ImemReady = rdy;
      #1;
      chk("imem_req", 32'(ImemReq), 32'(!rst));
      chk("imem_addr", ImemAddr, m_pc);
      @(posedge CLK);
      if (rst) begin
         m_pc = 32'h0; m_pend = 32'h0; m_drop = 1'b0;
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_stall_cnt = 32'h0; m_bub_cnt = 32'h0;
      end else begin
         redir = (src != 2'b00) && !sd;
         tgt   = src[1] ? jp : br;
         taken = !m_drop && rdy && !sf && !redir;
         if (!rdy && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
         if (!sd) begin
            if (taken) begin
               m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end else begin
               m_instr = 32'h0; m_valid = 1'b0;
               if (m_bub_cnt != 32'hFFFF_FFFF) m_bub_cnt++;
            end
         end
         if (m_drop) begin
            if (redir) m_pend = tgt;
            if (rdy) begin m_pc = m_pend; m_drop = 1'b0; end
         end else if (redir) begin
            if (rdy) m_pc = tgt;
            else begin m_pend = tgt; m_drop = 1'b1; end
         end else if (taken) begin
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
      chk("pcf", PCF, m_pc);
      chk("instr_d", InstrD, m_instr);
      chk("pcplus4_d", PCPlus4D, m_pc4);
      chk("valid_d", 32'(ValidD), 32'(m_valid));
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cycles", StallCycles, m_stall_cnt);
      chk("bubble_cycles", BubbleCycles, m_bub_cnt);
`endif
   endtask

   task automatic run(input logic rdy);
      step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, rdy);
   endtask

   initial begin
      logic        r_rst, r_sf, r_sd, r_rdy;
      logic [1:0]  r_src;
      logic [31:0] r_br, r_jp;
      int          kind;
      m_pc = 32'h0; m_pend = 32'h0; m_drop = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_stall_cnt = 32'h0; m_bub_cnt = 32'h0;
      RST = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 2'b00;
      PCBranchD = 32'h0; PCJumpD = 32'h0; ImemReady = 1'b1;

      // Reset state.
      step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      chk("rst_pcf", PCF, 32'h0);
      chk("rst_valid", 32'(ValidD), 32'h0);
      chk("rst_instr", InstrD, 32'h0);
      chk("rst_pc4", PCPlus4D, 32'h0);
      chk("rst_req", 32'(ImemReq), 32'h0);

      // Zero-wait sequential fetch.
      run(1'b1);
      chk("seq_pcf", PCF, 32'h4);
      chk("seq_instr", InstrD, 32'h1357_9BDF);
      chk("seq_pc4", PCPlus4D, 32'h4);
      chk("seq_valid", 32'(ValidD), 32'h1);
      run(1'b1); run(1'b1); run(1'b1);
      chk("seq_pcf_10", PCF, 32'h10);

      // Branch with one bubble.
      step(1'b0, 1'b0, 1'b0, 2'b01, 32'h40, 32'h0, 1'b1);
      chk("br_pcf", PCF, 32'h40);
      chk("br_bubble", 32'(ValidD), 32'h0);
      chk("br_nop", InstrD, 32'h0);
      run(1'b1);
      chk("br_pcf2", PCF, 32'h44);
      chk("br_instr", InstrD, mem_word(32'h40));
      chk("br_pc4", PCPlus4D, 32'h44);

      // Jump wins over branch.
      step(1'b0, 1'b0, 1'b0, 2'b11, 32'h80, 32'h100, 1'b1);
      chk("jmp_pcf", PCF, 32'h100);

      // Redirect during a memory wait.
      step(1'b0, 1'b0, 1'b0, 2'b01, 32'h20, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 2'b01, 32'h200, 32'h0, 1'b0);
      chk("drop_addr0", ImemAddr, 32'h20);
      run(1'b0);
      chk("drop_addr1", ImemAddr, 32'h20);
      chk("drop_valid1", 32'(ValidD), 32'h0);
      run(1'b0);
      chk("drop_addr2", ImemAddr, 32'h20);
      run(1'b1);
      chk("drop_pcf", PCF, 32'h200);
      chk("drop_valid3", 32'(ValidD), 32'h0);
      run(1'b1);
      chk("drop_instr", InstrD, mem_word(32'h200));
      chk("drop_valid4", 32'(ValidD), 32'h1);

      // Stall both stages; the pending branch is ignored.
      step(1'b0, 1'b1, 1'b1, 2'b01, 32'h80, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 2'b01, 32'h80, 32'h0, 1'b1);
      chk("stall_pcf", PCF, 32'h204);
      chk("stall_instr", InstrD, mem_word(32'h200));
      chk("stall_pc4", PCPlus4D, 32'h204);
      chk("stall_valid", 32'(ValidD), 32'h1);

      // PC+4 wraps.
      step(1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC, 1'b1);
      run(1'b1);
      chk("wrap_pcf", PCF, 32'h0);
      chk("wrap_pc4", PCPlus4D, 32'h0);

      // Reset while draining a stale response.
      step(1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h300, 1'b0);
      step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      chk("rdrop_req", 32'(ImemReq), 32'h0);
      chk("rdrop_pcf", PCF, 32'h0);
      chk("rdrop_valid", 32'(ValidD), 32'h0);
      run(1'b1);
      chk("rdrop_pcf2", PCF, 32'h4);
      chk("rdrop_instr", InstrD, mem_word(32'h0));

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(0, 199) == 0);
         r_rdy = ($urandom_range(0, 9) < 7);
         kind  = $urandom_range(0, 19);
         r_sf  = (kind == 0) || (kind == 2);
         r_sd  = (kind == 0) || (kind == 1);
         r_src = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (r_sf && !r_sd) r_src = 2'b00;
         r_br  = $urandom() & 32'hFFFF_FFFC;
         r_jp  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
         step(r_rst, r_sf, r_sd, r_src, r_br, r_jp, r_rdy);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
